// File: rtl/sd_cmd_serial_device_if.sv
// CMD-line and command/response signal bundle between an SD CMD device and its controller.
`timescale 1ns/1ps
interface sd_cmd_serial_device_if;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic         CMD_VALID;
    logic [5:0]   CMD_INDEX;
    logic [31:0]  CMD_ARG;
    logic         CRC_ERR;
    logic         FRAME_ERR;
    logic         RSP_REQ;
    logic         RSP_LONG;
    logic         RSP_NOCRC;
    logic         RSP_SKIP;
    logic [119:0] RSP_DATA;
    logic         RSP_BUSY;
    logic         RSP_DONE;

    modport slave (
        input  cmd_dat_i, RSP_REQ, RSP_LONG, RSP_NOCRC, RSP_SKIP, RSP_DATA,
        output cmd_out_o, cmd_oe_o, CMD_VALID, CMD_INDEX, CMD_ARG,
               CRC_ERR, FRAME_ERR, RSP_BUSY, RSP_DONE
    );

    modport master (
        output cmd_dat_i, RSP_REQ, RSP_LONG, RSP_NOCRC, RSP_SKIP, RSP_DATA,
        input  cmd_out_o, cmd_oe_o, CMD_VALID, CMD_INDEX, CMD_ARG,
               CRC_ERR, FRAME_ERR, RSP_BUSY, RSP_DONE
    );
endinterface

// File: rtl/sd_cmd_serial_device.sv
// SD card side CMD line: receives 48-bit commands and serialises R1/R3 (48-bit) or R2 (136-bit) responses.
// Optional receive CRC check: define SD_CMD_DEV_CRC_CHECK_EN.
`timescale 1ns/1ps
module sd_cmd_serial_device #(
    parameter int NCR = 2
) (
    input  logic SD_CLK_IN,
    input  logic RST_N_IN,
    sd_cmd_serial_device_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, TX_DLY, TX, TX_END} state_t;
    state_t state, state_nxt;

    localparam logic [6:0] NCR_M1 = 7'(NCR - 1);

`ifdef SD_CMD_DEV_CRC_CHECK_EN
    localparam int RX_W = 45;
`else
    localparam int RX_W = 38;
`endif
    localparam logic [5:0] RX_LAST = 6'(RX_W + 1);

    logic [5:0]      rx_cnt;
    logic [RX_W-1:0] rx_sr;
    logic [6:0]      ncr_cnt;
    logic [134:0]    tx_sr;
    logic [7:0]      tx_cnt;
    logic [6:0]      tx_crc;
    logic            tx_long;
    logic            tx_nocrc;
    logic [7:0]      tx_crc_lo, tx_crc_at, tx_last, tx_len;

    logic            cmd_out_r;
    logic            cmd_valid_r;
    logic            frame_err_r;
    logic [5:0]      cmd_index_r;
    logic [31:0]     cmd_arg_r;

    logic start_bit, frm_err, end_ok, cmd_ok, rsp_go, tx_go, crc_mis;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // R2 skips CRC over its 8 header bits; R1/R3 cover everything before the CRC field
    assign tx_crc_lo = tx_long ? 8'd8   : 8'd1;
    assign tx_crc_at = tx_long ? 8'd128 : 8'd40;
    assign tx_last   = tx_long ? 8'd135 : 8'd47;
    assign tx_len    = tx_long ? 8'd136 : 8'd48;

    always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_bit = 1'b0;
        frm_err   = 1'b0;
        end_ok    = 1'b0;
        cmd_ok    = 1'b0;
        rsp_go    = 1'b0;
        tx_go     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.cmd_dat_i) begin
                    start_bit = 1'b1;
                    state_nxt = RX;
                end
            end
            RX: begin
                if (rx_cnt == 6'd1 && !bus.cmd_dat_i) begin
                    frm_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (rx_cnt == 6'd47) begin
                    if (!bus.cmd_dat_i) begin
                        frm_err   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        end_ok = 1'b1;
                        if (crc_mis) begin
                            state_nxt = IDLE;
                        end else begin
                            cmd_ok    = 1'b1;
                            state_nxt = WAIT_RSP;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                // a host start bit means the host gave up on this response
                if (!bus.cmd_dat_i) begin
                    start_bit = 1'b1;
                    state_nxt = RX;
                end else if (bus.RSP_REQ) begin
                    rsp_go    = 1'b1;
                    state_nxt = TX_DLY;
                end else if (bus.RSP_SKIP) begin
                    state_nxt = IDLE;
                end
            end
            TX_DLY: begin
                if (ncr_cnt >= NCR_M1) begin
                    tx_go     = 1'b1;
                    state_nxt = TX;
                end
            end
            TX: begin
                if (tx_cnt == tx_len) state_nxt = TX_END;
            end
            TX_END:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            cmd_out_r   <= 1'b1;
            cmd_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            cmd_index_r <= '0;
            cmd_arg_r   <= '0;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            ncr_cnt     <= '0;
        end else begin
            cmd_valid_r <= cmd_ok;
            frame_err_r <= frm_err;
            if (cmd_ok) begin
                cmd_index_r <= rx_sr[RX_W-1 -: 6];
                cmd_arg_r   <= rx_sr[RX_W-7 -: 32];
            end
            if (start_bit)         rx_cnt <= 6'd1;
            else if (state == RX)  rx_cnt <= rx_cnt + 6'd1;
            // counts clocks since the end bit, saturating once NCR is met
            if (cmd_ok)                 ncr_cnt <= '0;
            else if (ncr_cnt < NCR_M1)  ncr_cnt <= ncr_cnt + 7'd1;
            if (tx_go) begin
                cmd_out_r <= 1'b0;
                tx_cnt    <= 8'd1;
            end else if (state == TX) begin
                tx_cnt <= tx_cnt + 8'd1;
                if (tx_cnt < tx_crc_at)    cmd_out_r <= tx_sr[134];
                else if (tx_cnt < tx_last) cmd_out_r <= tx_nocrc | tx_crc[6];
                else                       cmd_out_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge SD_CLK_IN) begin
        if (state == RX && rx_cnt >= 6'd2 && rx_cnt <= RX_LAST)
            rx_sr <= {rx_sr[RX_W-2:0], bus.cmd_dat_i};
        if (rsp_go) begin
            tx_long  <= bus.RSP_LONG;
            tx_nocrc <= bus.RSP_NOCRC;
            tx_sr    <= bus.RSP_LONG ? {1'b0, 6'h3F, bus.RSP_DATA, 8'h00}
                                     : {1'b0, bus.RSP_DATA[37:0], 96'h0};
        end else if (state == TX && tx_cnt < tx_crc_at) begin
            tx_sr <= {tx_sr[133:0], 1'b0};
        end
        if (tx_go) begin
            tx_crc <= 7'h00;
        end else if (state == TX) begin
            if (tx_cnt >= tx_crc_lo && tx_cnt < tx_crc_at) tx_crc <= crc7_step(tx_crc, tx_sr[134]);
            else if (tx_cnt >= tx_crc_at)                  tx_crc <= {tx_crc[5:0], 1'b0};
        end
    end

`ifdef SD_CMD_DEV_CRC_CHECK_EN
    logic [6:0] rx_crc;
    logic       crc_err_r;

    // start bit is 0 and the seed is 0, so accumulating from bit 1 is equivalent
    always_ff @(posedge SD_CLK_IN) begin
        if (start_bit)                            rx_crc <= 7'h00;
        else if (state == RX && rx_cnt <= 6'd39)  rx_crc <= crc7_step(rx_crc, bus.cmd_dat_i);
    end

    always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) crc_err_r <= 1'b0;
        else           crc_err_r <= end_ok & crc_mis;
    end

    assign crc_mis     = (rx_crc != rx_sr[6:0]);
    assign bus.CRC_ERR = crc_err_r;
`else
    assign crc_mis     = 1'b0;
    assign bus.CRC_ERR = 1'b0;
`endif

    assign bus.cmd_out_o = cmd_out_r;
    assign bus.cmd_oe_o  = (state == TX);
    assign bus.CMD_VALID = cmd_valid_r;
    assign bus.CMD_INDEX = cmd_index_r;
    assign bus.CMD_ARG   = cmd_arg_r;
    assign bus.FRAME_ERR = frame_err_r;
    assign bus.RSP_BUSY  = (state == TX_DLY) || (state == TX) || (state == TX_END);
    assign bus.RSP_DONE  = (state == TX_END);
endmodule

// File: tb/tb_sd_cmd_serial_device.sv
// Directed bench for sd_cmd_serial_device: command receive, R1/R2/R3 responses, framing errors, reset.
`timescale 1ns/1ps
module tb_sd_cmd_serial_device;
    localparam int NCR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_serial_device_if bus ();

    sd_cmd_serial_device #(.NCR(NCR)) dut (
        .SD_CLK_IN (clk),
        .RST_N_IN  (rst_n),
        .bus       (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cv_cnt  = 0;
    int fe_cnt  = 0;
    int ce_cnt  = 0;

    always @(negedge clk) begin
        if (bus.CMD_VALID === 1'b1) cv_cnt++;
        if (bus.FRAME_ERR === 1'b1) fe_cnt++;
        if (bus.CRC_ERR   === 1'b1) ce_cnt++;
    end

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] v, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg,
                                       input logic [6:0] crc, input logic tbit, input logic ebit);
        return {1'b0, tbit, idx, arg, crc, ebit};
    endfunction

    function automatic logic [47:0] mk_ok(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] v;
        v = '0;
        v[39:0] = {2'b01, idx, arg};
        return {1'b0, 1'b1, idx, arg, crc7(v, 40), 1'b1};
    endfunction

    task automatic send_bits(input logic [47:0] frm, input int nbits);
        for (int i = 47; i > 47 - nbits; i--) begin
            bus.cmd_dat_i = frm[i];
            tick();
        end
        bus.cmd_dat_i = 1'b1;
    endtask

    task automatic capture(output logic [135:0] bits, output int n);
        bits = '0;
        n = 0;
        while (bus.cmd_oe_o === 1'b1 && n < 200) begin
            bits = {bits[134:0], bus.cmd_out_o};
            n++;
            tick();
        end
    endtask

    task automatic request(input logic lng, input logic nocrc, input logic skip, input logic [119:0] d);
        bus.RSP_REQ   = 1'b1;
        bus.RSP_SKIP  = skip;
        bus.RSP_LONG  = lng;
        bus.RSP_NOCRC = nocrc;
        bus.RSP_DATA  = d;
        tick();
        bus.RSP_REQ  = 1'b0;
        bus.RSP_SKIP = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] bits, expv, v;
        int           n, cv0, fe0, ce0;
        logic [119:0] r2 = 120'h0123456789ABCDEFFEDCBA98765432;

        bus.cmd_dat_i = 1'b1;
        bus.RSP_REQ   = 1'b0;
        bus.RSP_LONG  = 1'b0;
        bus.RSP_NOCRC = 1'b0;
        bus.RSP_SKIP  = 1'b0;
        bus.RSP_DATA  = '0;
        repeat (3) tick();

        check_val("rst_oe",     bus.cmd_oe_o, 1'b0);
        check_val("rst_out",    bus.cmd_out_o, 1'b1);
        check_val("rst_idxarg", {bus.CMD_INDEX, bus.CMD_ARG}, 38'h0);
        check_val("rst_flags",  {bus.CMD_VALID, bus.FRAME_ERR, bus.CRC_ERR, bus.RSP_BUSY, bus.RSP_DONE}, 5'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // CMD0, start an R1, then reset at bit 20 of the response
        send_bits(mk(6'd0, 32'h0, 7'h4A, 1'b1, 1'b1), 48);
        check_val("cmd0_valid", bus.CMD_VALID, 1'b1);
        check_val("cmd0_idxarg", {bus.CMD_INDEX, bus.CMD_ARG}, 38'h0);
        request(1'b0, 1'b0, 1'b0, 120'h0);
        check_val("cmd0_vld_1cyc", bus.CMD_VALID, 1'b0);
        check_val("cmd0_wait_busy", bus.RSP_BUSY, 1'b1);
        tick();
        check_val("cmd0_rsp_start", {bus.cmd_oe_o, bus.cmd_out_o}, 2'b10);
        repeat (20) tick();
        check_val("midtx_oe", bus.cmd_oe_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("rst_midtx_oe", bus.cmd_oe_o, 1'b0);
        check_val("rst_midtx_out", bus.cmd_out_o, 1'b1);
        check_val("rst_midtx_flags", {bus.CMD_VALID, bus.FRAME_ERR, bus.CRC_ERR, bus.RSP_BUSY, bus.RSP_DONE}, 5'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // CMD8 with R1 response, start bit NCR clocks after the end bit
        send_bits(mk(6'd8, 32'h000001AA, 7'h43, 1'b1, 1'b1), 48);
        check_val("cmd8_valid", bus.CMD_VALID, 1'b1);
        check_val("cmd8_idxarg", {bus.CMD_INDEX, bus.CMD_ARG}, {6'd8, 32'h1AA});
        request(1'b0, 1'b0, 1'b0, {82'h0, 6'd8, 32'h1AA});
        check_val("cmd8_dly", {bus.cmd_oe_o, bus.RSP_BUSY}, 2'b01);
        tick();
        check_val("cmd8_ncr_start", {bus.cmd_oe_o, bus.cmd_out_o}, 2'b10);
        capture(bits, n);
        v = '0;
        v[39:0] = {2'b00, 6'd8, 32'h1AA};
        expv = '0;
        expv[47:0] = {2'b00, 6'd8, 32'h1AA, crc7(v, 40), 1'b1};
        check_val("r1_len", n, 48);
        check_val("r1_bits", bits, expv);
        check_val("r1_crc", bits[7:1], crc7(v, 40));
        check_val("r1_done", {bus.RSP_DONE, bus.RSP_BUSY, bus.cmd_out_o}, 3'b111);
        tick();
        check_val("r1_done_1cyc", {bus.RSP_DONE, bus.RSP_BUSY}, 2'b00);

        // new start bit while waiting for a response, then skip
        send_bits(mk(6'd0, 32'h0, 7'h4A, 1'b1, 1'b1), 48);
        tick();
        tick();
        send_bits(mk_ok(6'd8, 32'h000002AA), 48);
        check_val("restart_valid", bus.CMD_VALID, 1'b1);
        check_val("restart_idxarg", {bus.CMD_INDEX, bus.CMD_ARG}, {6'd8, 32'h2AA});
        bus.RSP_SKIP = 1'b1;
        tick();
        bus.RSP_SKIP = 1'b0;
        request(1'b0, 1'b0, 1'b0, 120'h0);
        check_val("skip_ignored_req", bus.RSP_BUSY, 1'b0);

        // CMD55 with a corrupted CRC
        cv0 = cv_cnt;
        ce0 = ce_cnt;
        send_bits(mk(6'd55, 32'h0, 7'h33, 1'b1, 1'b1), 48);
        tick();
`ifdef SD_CMD_DEV_CRC_CHECK_EN
        check_val("crc55_no_valid", cv_cnt - cv0, 0);
        check_val("crc55_err", ce_cnt - ce0, 1);
        check_val("crc55_hold_idx", bus.CMD_INDEX, 6'd8);
`else
        check_val("crc55_valid", cv_cnt - cv0, 1);
        check_val("crc55_no_err", ce_cnt - ce0, 0);
        check_val("crc55_idx", bus.CMD_INDEX, 6'd55);
`endif

        // CMD2 then a late R2 request with RSP_SKIP in the same cycle
        send_bits(mk_ok(6'd2, 32'h0), 48);
        check_val("cmd2_valid", bus.CMD_VALID, 1'b1);
        repeat (3) tick();
        request(1'b1, 1'b0, 1'b1, r2);
        check_val("r2_dly", {bus.cmd_oe_o, bus.RSP_BUSY}, 2'b01);
        tick();
        check_val("r2_start", {bus.cmd_oe_o, bus.cmd_out_o}, 2'b10);
        capture(bits, n);
        expv = {2'b00, 6'h3F, r2, crc7({16'h0, r2}, 120), 1'b1};
        check_val("r2_len", n, 136);
        check_val("r2_bits", bits, expv);
        check_val("r2_done", {bus.RSP_DONE, bus.cmd_oe_o, bus.cmd_out_o}, 3'b101);
        tick();
        check_val("r2_idle", {bus.RSP_DONE, bus.RSP_BUSY}, 2'b00);

        // CMD41 with an R3 response (CRC field all ones)
        send_bits(mk_ok(6'd41, 32'h40FF8000), 48);
        check_val("cmd41_valid", bus.CMD_VALID, 1'b1);
        request(1'b0, 1'b1, 1'b0, {82'h0, 6'h3F, 32'h80FF8000});
        tick();
        capture(bits, n);
        expv = '0;
        expv[47:0] = {2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        check_val("r3_len", n, 48);
        check_val("r3_bits", bits, expv);
        tick();

        // transmission bit 0 is rejected after two bits
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bits(mk(6'd0, 32'h0, 7'h0, 1'b0, 1'b1), 2);
        check_val("trans0_ferr", bus.FRAME_ERR, 1'b1);
        tick();
        check_val("trans0_cnt", {cv_cnt - cv0, fe_cnt - fe0}, {32'd0, 32'd1});

        // end bit 0
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        v = '0;
        v[39:0] = {2'b01, 6'd17, 32'h12345678};
        send_bits(mk(6'd17, 32'h12345678, crc7(v, 40), 1'b1, 1'b0), 48);
        check_val("end0_ferr", {bus.FRAME_ERR, bus.CMD_VALID}, 2'b10);
        tick();
        check_val("end0_cnt", {cv_cnt - cv0, fe_cnt - fe0}, {32'd0, 32'd1});
        check_val("end0_hold", {bus.CMD_INDEX, bus.CMD_ARG}, {6'd41, 32'h40FF8000});
        request(1'b0, 1'b0, 1'b0, 120'h0);
        check_val("end0_idle_req", bus.RSP_BUSY, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
